// File: rtl/isq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isq_pkg
// Description : Shared definitions for the integer square-root family.
//               Contains the reconstruct FSM state encoding, the default
//               operand widths and a constant-width helper.
//               Optional build macro used by this family: REMAINDER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package isq_pkg;

  // Reconstruct FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default widths: root, radicand/result, remainder
  localparam int Q_WIDTH_DEF = 16;
  localparam int D_WIDTH_DEF = 32;
  localparam int R_WIDTH_DEF = 17;

  // Smallest w with 2**w >= n.  Used to size the iteration counter,
  // which only has to reach n-1.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/isq_reconstruct_if.sv
`default_nettype none
// ============================================================================
// Module      : isq_reconstruct_if
// Description : Operand and result handshake bundle for isq_reconstruct.
//               Upstream side : in_valid / in_ready / q_i / r_i
//               Downstream    : out_valid / out_ready / data_o / o_err
//               o_err exists only when REMAINDER_CHECK_EN is defined.
//               modport slave  - the reconstruct block
//               modport master - the environment driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface isq_reconstruct_if
  import isq_pkg::*;
#(
  parameter int Q_WIDTH = Q_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int R_WIDTH = R_WIDTH_DEF
) ();

  logic               in_valid;
  logic               in_ready;
  logic [Q_WIDTH-1:0] q_i;
  logic [R_WIDTH-1:0] r_i;
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] data_o;
`ifdef REMAINDER_CHECK_EN
  logic               o_err;
`endif

`ifdef REMAINDER_CHECK_EN
  modport slave (
    input  in_valid, q_i, r_i, out_ready,
    output in_ready, out_valid, data_o, o_err
  );
  modport master (
    output in_valid, q_i, r_i, out_ready,
    input  in_ready, out_valid, data_o, o_err
  );
`else
  modport slave (
    input  in_valid, q_i, r_i, out_ready,
    output in_ready, out_valid, data_o
  );
  modport master (
    output in_valid, q_i, r_i, out_ready,
    input  in_ready, out_valid, data_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/isq_reconstruct.sv
`default_nettype none
// ============================================================================
// Module      : isq_reconstruct
// Description : Rebuilds a radicand from an integer square-root result:
//               data_o = q*q + r (mod 2**D_WIDTH).  Iterative shift-add
//               multiplier retiring one multiplier bit per clock, Q_WIDTH
//               cycles per operand, ready/valid on both sides.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               bus    - isq_reconstruct_if.slave (operand in, result out)
// Options     : REMAINDER_CHECK_EN - flags r > 2q on bus.o_err alongside
//               the result.  Without it o_err and the comparator are absent.
// Revision    : 1.0 - initial release
// ============================================================================
module isq_reconstruct
  import isq_pkg::*;
#(
  parameter int Q_WIDTH = Q_WIDTH_DEF,
  parameter int D_WIDTH = 2 * Q_WIDTH,
  parameter int R_WIDTH = Q_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  isq_reconstruct_if.slave   bus
);

  // The counter only has to reach Q_WIDTH-1; keep it at least 1 bit wide.
  localparam int               CNT_W    = (clog2(Q_WIDTH) < 1) ? 1 : clog2(Q_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Q_WIDTH - 1);

  state_e             state_q,     state_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [D_WIDTH-1:0] data_q,      data_d;
  logic [D_WIDTH-1:0] acc_q,       acc_d;
  logic [D_WIDTH-1:0] mcand_q,     mcand_d;
  logic [Q_WIDTH-1:0] mult_q,      mult_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  logic               accept;
  logic [D_WIDTH-1:0] acc_sum;

  // in_ready_q is only ever set while in IDLE, so it alone qualifies a take.
  assign accept  = bus.in_valid && in_ready_q;

  // Partial product for the current multiplier LSB; carry out is dropped,
  // which gives the modulo-2**D_WIDTH wrap for out-of-range remainders.
  assign acc_sum = mult_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef REMAINDER_CHECK_EN
  // One extra bit on both sides so 2*q never truncates before the compare.
  localparam int ERR_W = R_WIDTH + 1;
  logic err_q, err_d;
  logic rem_bad;
  assign rem_bad = ERR_W'(bus.r_i) > ERR_W'({bus.q_i, 1'b0});
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mult_d      = mult_q;
    cnt_d       = cnt_q;
`ifdef REMAINDER_CHECK_EN
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Seeding the accumulator with r folds the "+ r" into the multiply.
          acc_d   = D_WIDTH'(bus.r_i);
          mcand_d = D_WIDTH'(bus.q_i);
          mult_d  = bus.q_i;
          cnt_d   = '0;
          state_d = CALC;
`ifdef REMAINDER_CHECK_EN
          err_d   = rem_bad;
`endif
        end
      end

      CALC: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mult_d  = mult_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: publish the finished sum on the same edge it is formed.
        if (cnt_q == CNT_LAST) begin
          data_d      = acc_sum;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Registered ready: low throughout reset, high in every IDLE cycle after.
    in_ready_d = (state_d == IDLE);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mult_q      <= '0;
      cnt_q       <= '0;
`ifdef REMAINDER_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      cnt_q       <= cnt_d;
`ifdef REMAINDER_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_o    = data_q;
`ifdef REMAINDER_CHECK_EN
  // Flag is only meaningful alongside a valid result.
  assign bus.o_err     = err_q & out_valid_q;
`endif

endmodule
`default_nettype wire
